// File: rtl/instr_sequencer.sv
// Program store and issue stage feeding the shared opcode/execute bus of the
// GPU cores. The host loads 16-bit words while idle. A start request steps
// through the program from address 0. Reserved misc-class words (END, LOOP,
// NOP) steer the sequencer itself and never reach the cores.
//
// state | meaning
// IDLE  | program store writable, waiting for start, execute held low
// RUN   | fetching mem[pc] each unstalled cycle, issuing core words
module instr_sequencer #(
  parameter  int PROG_DEPTH = 32,
  parameter  int LOOP_WIDTH = 8,
  localparam int ADDR_WIDTH = $clog2(PROG_DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  prog_we,
  input  logic [ADDR_WIDTH-1:0] prog_addr,
  input  logic [15:0]           prog_data,
  input  logic [LOOP_WIDTH-1:0] loop_count,
  input  logic                  start,
  input  logic                  stall,
  output logic [15:0]           opcode,
  output logic                  execute,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] pc
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t                state_q, state_d;
  logic [15:0]           opcode_q, opcode_d;
  logic                  execute_q, execute_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [LOOP_WIDTH-1:0] loop_cnt_q, loop_cnt_d;

  logic [15:0] mem [PROG_DEPTH];
  logic [15:0] word;
  logic        is_ctrl;
  logic        at_last;
  logic        finish;

  assign word    = mem[pc_q];
  assign is_ctrl = (word[15:14] == 2'b11) && !word[8];
  assign at_last = (pc_q == ADDR_WIDTH'(PROG_DEPTH - 1));

  // Program store: not reset, so a loaded program survives a sequencer reset.
  always_ff @(posedge clk) begin
    if (prog_we && (state_q == IDLE)) begin
      mem[prog_addr] <= prog_data;
    end
  end

  // Next-state decode: start handling, stall hold, core/control word decode.
  always_comb begin
    state_d    = state_q;
    opcode_d   = opcode_q;
    execute_d  = 1'b0;
    busy_d     = busy_q;
    done_d     = 1'b0;
    pc_d       = pc_q;
    loop_cnt_d = loop_cnt_q;
    finish     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          pc_d       = '0;
          loop_cnt_d = loop_count;
          state_d    = RUN;
          busy_d     = 1'b1;
        end
      end
      RUN: begin
        if (!stall) begin
          if (!is_ctrl) begin
            opcode_d  = word;
            execute_d = 1'b1;
            pc_d      = pc_q + ADDR_WIDTH'(1);
          end else begin
            case (word[7:6])
              2'b01: finish = 1'b1;
              2'b10: begin
                if (loop_cnt_q != '0) begin
                  loop_cnt_d = loop_cnt_q - LOOP_WIDTH'(1);
                  pc_d       = word[ADDR_WIDTH-1:0];
                end else begin
                  // Reload so a later LOOP word starts its count fresh.
                  loop_cnt_d = loop_count;
                  pc_d       = pc_q + ADDR_WIDTH'(1);
                end
              end
              default: pc_d = pc_q + ADDR_WIDTH'(1);
            endcase
          end
          // The last word of the store ends the program; the pc never wraps.
          if (finish || at_last) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pc_d    = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Sequencer state and registered bus outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      opcode_q   <= '0;
      execute_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pc_q       <= '0;
      loop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      opcode_q   <= opcode_d;
      execute_q  <= execute_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pc_q       <= pc_d;
      loop_cnt_q <= loop_cnt_d;
    end
  end

  assign opcode  = opcode_q;
  assign execute = execute_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign pc      = pc_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: inputs change and outputs are sampled on
// the falling clock edge, away from the active rising edge.
module tb_instr_sequencer;

  localparam int PROG_DEPTH = 32;
  localparam int LOOP_WIDTH = 8;
  localparam int AW         = 5;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  prog_we;
  logic [AW-1:0]         prog_addr;
  logic [15:0]           prog_data;
  logic [LOOP_WIDTH-1:0] loop_count;
  logic                  start;
  logic                  stall;
  logic [15:0]           opcode;
  logic                  execute;
  logic                  busy;
  logic                  done;
  logic [AW-1:0]         pc;

  instr_sequencer #(.PROG_DEPTH(PROG_DEPTH), .LOOP_WIDTH(LOOP_WIDTH)) dut (
    .clk(clk), .reset(reset), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .loop_count(loop_count), .start(start),
    .stall(stall), .opcode(opcode), .execute(execute), .busy(busy),
    .done(done), .pc(pc)
  );

  always #5 clk = ~clk;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [15:0] ops [64];
  int          n_issue;
  logic        exec_bits [128];
  logic [AW-1:0] pcs [128];
  logic [15:0] opc_hist [128];
  int          done_cyc;
  logic        busy_at_done;
  logic [AW-1:0] pc_at_done;
  logic        exec_after, done_after, busy_after;
  bit          timed_out;

  task automatic wr(input logic [AW-1:0] a, input logic [15:0] d);
    @(negedge clk);
    prog_we = 1'b1; prog_addr = a; prog_data = d;
    @(negedge clk);
    prog_we = 1'b0;
  endtask

  // Pulses start (optionally with a same-cycle write), records every sampled
  // cycle until done, then samples one cycle beyond done.
  task automatic run_prog(input int max_cyc, input int stall_at, input int stall_len,
                          input bit we_en, input logic [AW-1:0] wa, input logic [15:0] wd);
    n_issue = 0; done_cyc = -1; timed_out = 1'b0;
    @(negedge clk);
    start = 1'b1; prog_we = we_en; prog_addr = wa; prog_data = wd;
    @(negedge clk);
    start = 1'b0; prog_we = 1'b0;
    for (int c = 1; c <= max_cyc; c++) begin
      @(negedge clk);
      exec_bits[c] = execute; pcs[c] = pc; opc_hist[c] = opcode;
      if (execute && n_issue < 64) begin
        ops[n_issue] = opcode;
        n_issue++;
      end
      stall = (c >= stall_at) && (c < stall_at + stall_len);
      if (done) begin
        done_cyc = c; busy_at_done = busy; pc_at_done = pc;
        break;
      end
    end
    if (done_cyc < 0) timed_out = 1'b1;
    stall = 1'b0;
    @(negedge clk);
    exec_after = execute; done_after = done; busy_after = busy;
  endtask

  task automatic test_reset();
    reset = 1'b1; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
    loop_count = '0; start = 1'b0; stall = 1'b0;
    repeat (2) @(negedge clk);
    total_cnt++; if (opcode !== 16'h0) $display("FAIL reset_opcode got %h want 0000", opcode); else pass_cnt++;
    total_cnt++; if (execute !== 1'b0) $display("FAIL reset_execute got %b want 0", execute); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else pass_cnt++;
    total_cnt++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else pass_cnt++;
    total_cnt++; if (pc !== 5'd0) $display("FAIL reset_pc got %0d want 0", pc); else pass_cnt++;
    reset = 1'b0;
    // Stall held while idle must not start anything.
    stall = 1'b1;
    repeat (3) @(negedge clk);
    stall = 1'b0;
    total_cnt++; if (busy !== 1'b0) $display("FAIL idle_stall_busy got %b want 0", busy); else pass_cnt++;
  endtask

  task automatic test_basic();
    wr(0, 16'h0005); wr(1, 16'h4000); wr(2, 16'hC040);
    loop_count = 8'd0;
    run_prog(40, 0, 0, 1'b0, '0, '0);
    total_cnt++; if (timed_out !== 1'b0) $display("FAIL basic_timeout got %b want 0", timed_out); else pass_cnt++;
    total_cnt++; if (n_issue !== 2) $display("FAIL basic_issues got %0d want 2", n_issue); else pass_cnt++;
    total_cnt++; if (ops[0] !== 16'h0005) $display("FAIL basic_op0 got %h want 0005", ops[0]); else pass_cnt++;
    total_cnt++; if (ops[1] !== 16'h4000) $display("FAIL basic_op1 got %h want 4000", ops[1]); else pass_cnt++;
    total_cnt++; if (exec_bits[1] !== 1'b1) $display("FAIL basic_latency got %b want 1", exec_bits[1]); else pass_cnt++;
    total_cnt++; if (done_cyc !== 3) $display("FAIL basic_done_cyc got %0d want 3", done_cyc); else pass_cnt++;
    total_cnt++; if (busy_at_done !== 1'b0) $display("FAIL basic_busy_at_done got %b want 0", busy_at_done); else pass_cnt++;
    total_cnt++; if (pc_at_done !== 5'd0) $display("FAIL basic_pc_at_done got %0d want 0", pc_at_done); else pass_cnt++;
    total_cnt++; if (done_after !== 1'b0) $display("FAIL basic_done_width got %b want 0", done_after); else pass_cnt++;
  endtask

  task automatic test_loop();
    wr(0, 16'h8000); wr(1, 16'hC080); wr(2, 16'hC040);
    loop_count = 8'd3;
    run_prog(40, 0, 0, 1'b0, '0, '0);
    total_cnt++; if (n_issue !== 4) $display("FAIL loop_issues got %0d want 4", n_issue); else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      total_cnt++; if (ops[i] !== 16'h8000) $display("FAIL loop_op%0d got %h want 8000", i, ops[i]); else pass_cnt++;
    end
    total_cnt++; if (done_cyc !== 9) $display("FAIL loop_done_cyc got %0d want 9", done_cyc); else pass_cnt++;
    if (done_cyc == 9) begin
      for (int c = 1; c <= 9; c++) begin
        logic want;
        want = (c % 2 == 1) && (c < 8);
        total_cnt++; if (exec_bits[c] !== want) $display("FAIL loop_exec_c%0d got %b want %b", c, exec_bits[c], want); else pass_cnt++;
      end
    end
    loop_count = 8'd1;
    run_prog(40, 0, 0, 1'b0, '0, '0);
    total_cnt++; if (n_issue !== 2) $display("FAIL loop1_issues got %0d want 2", n_issue); else pass_cnt++;
    total_cnt++; if (done_cyc !== 5) $display("FAIL loop1_done_cyc got %0d want 5", done_cyc); else pass_cnt++;
  endtask

  task automatic test_stall();
    wr(0, 16'h0001); wr(1, 16'h0002); wr(2, 16'h0003); wr(3, 16'h0004); wr(4, 16'hC040);
    loop_count = 8'd0;
    run_prog(40, 2, 3, 1'b0, '0, '0);
    total_cnt++; if (n_issue !== 4) $display("FAIL stall_issues got %0d want 4", n_issue); else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      total_cnt++; if (ops[i] !== 16'(i + 1)) $display("FAIL stall_op%0d got %h want %h", i, ops[i], 16'(i + 1)); else pass_cnt++;
    end
    for (int c = 3; c <= 5; c++) begin
      total_cnt++; if (exec_bits[c] !== 1'b0) $display("FAIL stall_exec_c%0d got %b want 0", c, exec_bits[c]); else pass_cnt++;
      total_cnt++; if (pcs[c] !== 5'd2) $display("FAIL stall_pc_c%0d got %0d want 2", c, pcs[c]); else pass_cnt++;
    end
    total_cnt++; if (opc_hist[5] !== 16'h0002) $display("FAIL stall_opcode_hold got %h want 0002", opc_hist[5]); else pass_cnt++;
    total_cnt++; if (done_cyc !== 8) $display("FAIL stall_done_cyc got %0d want 8", done_cyc); else pass_cnt++;
  endtask

  task automatic test_end_of_mem();
    for (int a = 0; a < PROG_DEPTH; a++) wr(AW'(a), 16'h4000);
    loop_count = 8'd0;
    run_prog(100, 0, 0, 1'b0, '0, '0);
    total_cnt++; if (n_issue !== 32) $display("FAIL eom_issues got %0d want 32", n_issue); else pass_cnt++;
    total_cnt++; if (done_cyc !== 32) $display("FAIL eom_done_cyc got %0d want 32", done_cyc); else pass_cnt++;
    total_cnt++; if (pc_at_done !== 5'd0) $display("FAIL eom_pc got %0d want 0", pc_at_done); else pass_cnt++;
    total_cnt++; if (exec_after !== 1'b0) $display("FAIL eom_no_wrap_exec got %b want 0", exec_after); else pass_cnt++;
    total_cnt++; if (busy_after !== 1'b0) $display("FAIL eom_busy_after got %b want 0", busy_after); else pass_cnt++;
  endtask

  task automatic test_reset_mid_run();
    bit saw_activity;
    wr(0, 16'h0011); wr(1, 16'h0022); wr(2, 16'h0033); wr(3, 16'h0044); wr(4, 16'hC040);
    loop_count = 8'd0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    total_cnt++; if (execute !== 1'b0) $display("FAIL rst_run_execute got %b want 0", execute); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL rst_run_busy got %b want 0", busy); else pass_cnt++;
    total_cnt++; if (pc !== 5'd0) $display("FAIL rst_run_pc got %0d want 0", pc); else pass_cnt++;
    saw_activity = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (done || execute) saw_activity = 1'b1;
      @(negedge clk);
    end
    total_cnt++; if (saw_activity !== 1'b0) $display("FAIL rst_run_no_done got %b want 0", saw_activity); else pass_cnt++;
    run_prog(40, 0, 0, 1'b0, '0, '0);
    total_cnt++; if (n_issue !== 4) $display("FAIL rerun_issues got %0d want 4", n_issue); else pass_cnt++;
    total_cnt++; if (ops[3] !== 16'h0044) $display("FAIL rerun_op3 got %h want 0044", ops[3]); else pass_cnt++;
  endtask

  task automatic test_write_while_busy();
    bit seen_done;
    logic [15:0] op_c2;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    prog_we = 1'b1; prog_addr = 5'd1; prog_data = 16'hBEEF;
    seen_done = 1'b0; op_c2 = '0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (c == 2) op_c2 = opcode;
      if (c == 3) prog_we = 1'b0;
      if (done) begin seen_done = 1'b1; break; end
    end
    prog_we = 1'b0;
    total_cnt++; if (seen_done !== 1'b1) $display("FAIL wbusy_done got %b want 1", seen_done); else pass_cnt++;
    total_cnt++; if (op_c2 !== 16'h0022) $display("FAIL wbusy_cur_op got %h want 0022", op_c2); else pass_cnt++;
    run_prog(40, 0, 0, 1'b0, '0, '0);
    total_cnt++; if (ops[1] !== 16'h0022) $display("FAIL wbusy_next_op1 got %h want 0022", ops[1]); else pass_cnt++;
  endtask

  task automatic test_start_with_write();
    run_prog(40, 0, 0, 1'b1, 5'd0, 16'h0077);
    total_cnt++; if (ops[0] !== 16'h0077) $display("FAIL swr_op0 got %h want 0077", ops[0]); else pass_cnt++;
    total_cnt++; if (n_issue !== 4) $display("FAIL swr_issues got %0d want 4", n_issue); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_loop();
    test_stall();
    test_end_of_mem();
    test_reset_mid_run();
    test_write_while_busy();
    test_start_with_write();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
